// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM state
// encoding, the default NOP word and the word-address helper.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // addi x0,x0,0 -- driven whenever no live fetched word is held
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    // Clear the byte offset so the address points at a 32-bit word
    function automatic logic [63:0] word_addr(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_linebuf.sv
// One-entry fetch line buffer: remembers the last delivered word and its
// word-address tag so an immediate refetch of the same PC can skip memory.
// Only instantiated when FETCH_LINEBUF_EN is defined.
module fetch_linebuf #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fill,
    input  logic [SIZE-3:0] fill_tag,
    input  logic [31:0]     fill_data,
    input  logic [SIZE-3:0] lookup_tag,
    output logic            hit,
    output logic [31:0]     hit_data
);

    logic            valid_r;
    logic [SIZE-3:0] tag_r;
    logic [31:0]     data_r;

    // Capture every delivered word; the entry is invalid only after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
            data_r  <= 32'h0000_0000;
        end else if (fill) begin
            valid_r <= 1'b1;
            tag_r   <= fill_tag;
            data_r  <= fill_data;
        end else begin
            valid_r <= valid_r;
            tag_r   <= tag_r;
            data_r  <= data_r;
        end
    end

    assign hit      = valid_r && (tag_r == lookup_tag);
    assign hit_data = data_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding word request to instruction
// memory, redirect-aware discard of stale responses, and stallF generation
// towards the fetch/decode controller.
// Optional build macro FETCH_LINEBUF_EN adds a one-entry line buffer that
// serves an immediate refetch of the last delivered word without memory.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          SIZE      = 32,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] pc,
    input  logic            redirect,
    input  logic            hazard_stall,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [SIZE-1:0] mem_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic            stallF
);

    fetch_state_e    state_r, state_s;
    logic            discard_r, discard_s;
    logic [SIZE-1:0] addr_r, addr_s;
    logic [31:0]     instr_r, instr_s;
    logic            ivalid_r, ivalid_s;
    logic            req_valid_r;
    logic            fill_s;
    logic            hit_s;
    logic [31:0]     hit_data_s;
    logic [SIZE-1:0] aligned_pc_s;

    // Where a fresh fetch lands: straight to HOLD on a buffer hit, else REQ
    fetch_state_e    entry_state_s;
    logic [SIZE-1:0] entry_addr_s;
    logic [31:0]     entry_instr_s;
    logic            entry_ivalid_s;

    assign aligned_pc_s = SIZE'(word_addr(64'(pc)));

`ifdef FETCH_LINEBUF_EN
    fetch_linebuf #(
        .SIZE(SIZE)
    ) u_linebuf (
        .clk        (clk),
        .rst_n      (rst),
        .fill       (fill_s),
        .fill_tag   (addr_r[SIZE-1:2]),
        .fill_data  (mem_resp_data),
        .lookup_tag (pc[SIZE-1:2]),
        .hit        (hit_s),
        .hit_data   (hit_data_s)
    );
`else
    logic linebuf_unused_s;
    assign linebuf_unused_s = fill_s;
    assign hit_s            = 1'b0;
    assign hit_data_s       = NOP_INSTR;
`endif

    // Resolve the landing point of a new fetch from the buffer lookup
    always_comb begin
        entry_state_s  = REQ;
        entry_addr_s   = aligned_pc_s;
        entry_instr_s  = NOP_INSTR;
        entry_ivalid_s = 1'b0;
        if (hit_s) begin
            entry_state_s  = HOLD;
            entry_addr_s   = addr_r;
            entry_instr_s  = hit_data_s;
            entry_ivalid_s = 1'b1;
        end else begin
            entry_state_s  = REQ;
        end
    end

    // Next-state and datapath updates; redirect outranks hazard_stall
    always_comb begin
        state_s   = state_r;
        discard_s = discard_r;
        addr_s    = addr_r;
        instr_s   = instr_r;
        ivalid_s  = ivalid_r;
        fill_s    = 1'b0;
        case (state_r)
            IDLE: begin
                state_s  = entry_state_s;
                addr_s   = entry_addr_s;
                instr_s  = entry_instr_s;
                ivalid_s = entry_ivalid_s;
            end
            REQ: begin
                // The address is held; a redirect only marks the reply stale
                discard_s = discard_r | redirect;
                if (mem_req_ready) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (discard_r || redirect) begin
                        discard_s = 1'b0;
                        state_s   = entry_state_s;
                        addr_s    = entry_addr_s;
                        instr_s   = entry_instr_s;
                        ivalid_s  = entry_ivalid_s;
                    end else begin
                        state_s   = HOLD;
                        instr_s   = mem_resp_data;
                        ivalid_s  = 1'b1;
                        fill_s    = 1'b1;
                    end
                end else begin
                    discard_s = discard_r | redirect;
                end
            end
            HOLD: begin
                if (redirect || !hazard_stall) begin
                    state_s  = entry_state_s;
                    addr_s   = entry_addr_s;
                    instr_s  = entry_instr_s;
                    ivalid_s = entry_ivalid_s;
                end else begin
                    state_s  = HOLD;
                end
            end
            default: begin
                state_s   = IDLE;
                discard_s = 1'b0;
                instr_s   = NOP_INSTR;
                ivalid_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            discard_r   <= 1'b0;
            addr_r      <= '0;
            instr_r     <= NOP_INSTR;
            ivalid_r    <= 1'b0;
            req_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            discard_r   <= discard_s;
            addr_r      <= addr_s;
            instr_r     <= instr_s;
            ivalid_r    <= ivalid_s;
            req_valid_r <= (state_s == REQ);
        end
    end

    assign mem_req_valid = req_valid_r;
    assign mem_addr      = addr_r;
    assign instr         = instr_r;
    assign instr_valid   = ivalid_r;
    // Built from the registered state only, never from the response path
    assign stallF        = hazard_stall | (state_r != HOLD);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a directed vector table for the documented
// corner cases, then randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        redirect, hazard_stall;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [31:0] instr;
    logic        instr_valid, stallF;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.SIZE(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .redirect       (redirect),
        .hazard_stall   (hazard_stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .stallF         (stallF)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        redir;
        logic        haz;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_iv;
        logic        e_stall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [31:0] p, input logic rdr, input logic hz,
                       input logic rd_y, input logic rv, input logic [31:0] rd,
                       input logic eq, input logic [31:0] ea, input logic [31:0] ei,
                       input logic eiv, input logic est);
        vec_t v;
        v.rst = r; v.pc = p; v.redir = rdr; v.haz = hz; v.rdy = rd_y; v.rv = rv; v.rd = rd;
        v.e_req = eq; v.e_addr = ea; v.e_instr = ei; v.e_iv = eiv; v.e_stall = est;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic eq, input logic [31:0] ea,
                         input logic [31:0] ei, input logic eiv, input logic est);
        logic [66:0] got, want;
        got  = {mem_req_valid, mem_addr, instr, instr_valid, stallF};
        want = {eq, ea, ei, eiv, est};
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got req=%b addr=%h instr=%h iv=%b stallF=%b, want req=%b addr=%h instr=%h iv=%b stallF=%b",
                     nm, mem_req_valid, mem_addr, instr, instr_valid, stallF, eq, ea, ei, eiv, est);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_started, m_req_pend, m_req_stale, m_out, m_out_stale, m_have;
    logic [31:0] m_req_addr, m_instr;
    bit          mb_valid;
    logic [31:0] mb_tag, mb_data;

    task automatic model_reset();
        m_started = 0; m_req_pend = 0; m_req_stale = 0; m_out = 0; m_out_stale = 0;
        m_have = 0; m_req_addr = 32'h0; m_instr = NOP; mb_valid = 0;
        mb_tag = 32'h0; mb_data = 32'h0;
    endtask

    // Advance the model across one rising edge with the current inputs
    task automatic model_step();
        bit need_fetch;
        need_fetch = 0;
        if (!m_started) begin
            m_started  = 1;
            need_fetch = 1;
        end else if (m_req_pend) begin
            if (redirect) m_req_stale = 1;
            if (mem_req_ready) begin
                m_req_pend  = 0;
                m_out       = 1;
                m_out_stale = m_req_stale;
                m_req_stale = 0;
            end
        end else if (m_out) begin
            if (redirect) m_out_stale = 1;
            if (mem_resp_valid) begin
                m_out = 0;
                if (m_out_stale) begin
                    need_fetch = 1;
                end else begin
                    m_have   = 1;
                    m_instr  = mem_resp_data;
                    mb_valid = 1;
                    mb_tag   = m_req_addr;
                    mb_data  = mem_resp_data;
                end
            end
        end else if (m_have) begin
            if (redirect || !hazard_stall) begin
                m_have     = 0;
                m_instr    = NOP;
                need_fetch = 1;
            end
        end
        if (need_fetch) begin
`ifdef FETCH_LINEBUF_EN
            if (mb_valid && mb_tag == (pc & ~32'd3)) begin
                m_have  = 1;
                m_instr = mb_data;
            end else begin
                m_req_pend  = 1;
                m_req_stale = 0;
                m_req_addr  = pc & ~32'd3;
            end
`else
            m_req_pend  = 1;
            m_req_stale = 0;
            m_req_addr  = pc & ~32'd3;
`endif
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F ^ (a << 7);
    endfunction

    // Safety net against a stuck simulation
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          mbusy;
        int          mdelay;
        logic [31:0] maddr;

        rst = 1'b0; pc = 32'h0; redirect = 1'b0; hazard_stall = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;

        //   rst pc            rd hz ry rv data           | req addr           instr          iv st
        add(0, 32'h0000_0000, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0000, NOP,           0, 1);
        add(1, 32'h0000_0000, 0, 0, 1, 0, 32'h0,         1, 32'h0000_0000, NOP,           0, 1);
        add(1, 32'h0000_0000, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0000, NOP,           0, 1);
        add(1, 32'h0000_0000, 0, 0, 1, 1, 32'h0050_0093, 0, 32'h0000_0000, 32'h0050_0093, 1, 0);
        add(1, 32'h0000_0040, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0040, NOP,           0, 1);
        for (int i = 0; i < 3; i++)
            add(1, 32'h0000_0040, 0, 0, 0, 0, 32'h0,     1, 32'h0000_0040, NOP,           0, 1);
        add(1, 32'h0000_0040, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0040, NOP,           0, 1);
        add(1, 32'h0000_0040, 0, 1, 1, 1, 32'h1111_1111, 0, 32'h0000_0040, 32'h1111_1111, 1, 1);
        for (int i = 0; i < 3; i++)
            add(1, 32'h0000_0040, 0, 1, 1, 0, 32'h0,     0, 32'h0000_0040, 32'h1111_1111, 1, 1);
        add(1, 32'h0000_0044, 0, 0, 1, 0, 32'h0,         1, 32'h0000_0044, NOP,           0, 1);
        add(1, 32'h0000_0044, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0044, NOP,           0, 1);
        add(1, 32'h0000_0044, 1, 0, 1, 0, 32'h0,         0, 32'h0000_0044, NOP,           0, 1);
        add(1, 32'h0000_0100, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h0000_0100, NOP,           0, 1);
        add(1, 32'h0000_0100, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0100, NOP,           0, 1);
        add(1, 32'h0000_0100, 0, 0, 1, 1, 32'h00A0_0113, 0, 32'h0000_0100, 32'h00A0_0113, 1, 0);
        add(1, 32'h0000_0200, 0, 0, 1, 0, 32'h0,         1, 32'h0000_0200, NOP,           0, 1);
        add(1, 32'h0000_0200, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0200, NOP,           0, 1);
        add(0, 32'h0000_0200, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0000, NOP,           0, 1);
        add(1, 32'h0000_0200, 0, 0, 0, 1, 32'hBADB_AD00, 1, 32'h0000_0200, NOP,           0, 1);
        add(1, 32'h0000_0200, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0200, NOP,           0, 1);
        add(1, 32'h0000_0200, 0, 0, 1, 1, 32'h1234_5678, 0, 32'h0000_0200, 32'h1234_5678, 1, 0);
        add(1, 32'h0000_0300, 1, 1, 0, 0, 32'h0,         1, 32'h0000_0300, NOP,           0, 1);
        add(1, 32'h0000_0300, 1, 0, 0, 0, 32'h0,         1, 32'h0000_0300, NOP,           0, 1);
        add(1, 32'h0000_0304, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0300, NOP,           0, 1);
        add(1, 32'h0000_0304, 0, 0, 0, 1, 32'hAAAA_0000, 1, 32'h0000_0304, NOP,           0, 1);
        add(1, 32'h0000_0304, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0304, NOP,           0, 1);
        add(1, 32'h0000_0304, 0, 0, 1, 1, 32'h5555_0000, 0, 32'h0000_0304, 32'h5555_0000, 1, 0);
        add(1, 32'h0000_040B, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0408, NOP,           0, 1);
        add(1, 32'h0000_040B, 0, 0, 0, 1, 32'h6666_6666, 1, 32'h0000_0408, NOP,           0, 1);
        add(1, 32'h0000_040B, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0408, NOP,           0, 1);
        add(1, 32'h0000_0500, 1, 0, 1, 1, 32'h9999_9999, 1, 32'h0000_0500, NOP,           0, 1);
        add(1, 32'h0000_0500, 1, 0, 1, 0, 32'h0,         0, 32'h0000_0500, NOP,           0, 1);
        add(1, 32'h0000_0504, 0, 0, 1, 1, 32'h7777_7777, 1, 32'h0000_0504, NOP,           0, 1);
        add(1, 32'h0000_0504, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0504, NOP,           0, 1);
        add(1, 32'h0000_0504, 0, 0, 1, 1, 32'h0BAD_F00D, 0, 32'h0000_0504, 32'h0BAD_F00D, 1, 0);
`ifdef FETCH_LINEBUF_EN
        add(1, 32'h0000_0080, 0, 0, 1, 0, 32'h0,         1, 32'h0000_0080, NOP,           0, 1);
        add(1, 32'h0000_0080, 0, 0, 1, 0, 32'h0,         0, 32'h0000_0080, NOP,           0, 1);
        add(1, 32'h0000_0080, 0, 1, 1, 1, 32'hCAFE_0080, 0, 32'h0000_0080, 32'hCAFE_0080, 1, 1);
        add(1, 32'h0000_0080, 1, 0, 1, 0, 32'h0,         0, 32'h0000_0080, 32'hCAFE_0080, 1, 0);
`endif

        // Directed vectors: drive on the falling edge, check after the next rise
        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; pc = tbl[i].pc; redirect = tbl[i].redir;
            hazard_stall = tbl[i].haz; mem_req_ready = tbl[i].rdy;
            mem_resp_valid = tbl[i].rv; mem_resp_data = tbl[i].rd;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_instr,
                  tbl[i].e_iv, tbl[i].e_stall);
        end

        // Randomized traffic against the model
        rst = 1'b0; redirect = 1'b0; hazard_stall = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        model_reset();
        mbusy = 0; mdelay = 0; maddr = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (mbusy) begin
                if (mdelay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = memfn(maddr);
                    mbusy          = 0;
                end else begin
                    mdelay--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                mem_resp_valid = 1'b1;
            end
            mem_req_ready = ($urandom_range(0, 2) != 0);
            hazard_stall  = ($urandom_range(0, 2) == 0);
            redirect      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0)
                pc = 32'h0000_0080 + 32'($urandom_range(0, 3)) * 32'd4;
            else
                pc = $urandom;
            if (mem_req_valid && mem_req_ready && !mbusy) begin
                mbusy  = 1;
                mdelay = $urandom_range(0, 2);
                maddr  = mem_addr;
            end
            model_step();
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rand%0d", cyc), m_req_pend, m_req_addr, m_instr, m_have,
                  hazard_stall | !m_have);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
